// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB serial path.
// UART_APB_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_apb_pkg;

  localparam int unsigned BAUD_W_DEF   = 20;
  localparam int unsigned DATA_LEN_8   = 8;
  localparam int unsigned DATA_LEN_10  = 10;
  localparam logic        IDLE_LVL_DEF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_APB_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_apb_baud_tick.sv
// Bit timer: counts 0..max(div,1)-1 while enabled and pulses tick_o on the wrap.
// Shared between the transmitter and a future receiver.
module uart_apb_baud_tick #(
  parameter int unsigned BAUD_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BAUD_W-1:0] div_i,
  output logic              tick_o
);

  logic [BAUD_W-1:0] cnt_q;
  logic [BAUD_W-1:0] lim;

  // A divisor of 0 behaves as 1, so the limit never underflows.
  assign lim    = (div_i == '0) ? '0 : div_i - BAUD_W'(1);
  assign tick_o = en_i && (cnt_q == lim);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uart_apb_tx.sv
// Frame transmitter: start bit, 8/10 data bits LSB-first, optional even parity, stop bit.
// Define UART_APB_TX_PARITY_EN to insert the parity bit.
module uart_apb_tx
  import uart_apb_pkg::*;
#(
  parameter int unsigned BAUD_W   = BAUD_W_DEF,
  parameter logic        IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [9:0]        din,
  input  logic              mode,
  input  logic [BAUD_W-1:0] baud,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic              set_q;
  logic [9:0]        shift_q;
  logic              mode_q;
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bitcnt_q;
  logic              tx_q;
  logic              busy_q;
  logic              req;
  logic              last_bit;
  logic              tick;
`ifdef UART_APB_TX_PARITY_EN
  logic              par_q;
`endif

  assign req      = set & ~set_q;
  assign last_bit = (bitcnt_q == (mode_q ? 4'(DATA_LEN_10 - 1) : 4'(DATA_LEN_8 - 1)));

  uart_apb_baud_tick #(
    .BAUD_W (BAUD_W)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (state_q != ST_IDLE),
    .div_i  (baud_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      set_q    <= 1'b0;
      shift_q  <= '0;
      mode_q   <= 1'b0;
      baud_q   <= '0;
      bitcnt_q <= '0;
      tx_q     <= IDLE_LVL;
      busy_q   <= 1'b0;
`ifdef UART_APB_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      set_q <= set;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            shift_q  <= din;
            mode_q   <= mode;
            baud_q   <= baud;
            bitcnt_q <= '0;
`ifdef UART_APB_TX_PARITY_EN
            par_q    <= mode ? ^din : ^din[7:0];
`endif
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          // tx is registered, so the next bit is taken from shift_q[1] before the shift lands.
          if (tick) begin
            shift_q  <= shift_q >> 1;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (last_bit) begin
`ifdef UART_APB_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= IDLE_LVL;
              state_q <= ST_STOP;
`endif
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
`ifdef UART_APB_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx_q    <= IDLE_LVL;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_q    <= IDLE_LVL;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  // Completion is the wrap cycle of STOP, one cycle ahead of busy falling.
  assign done = (state_q == ST_STOP) && tick;

endmodule

// File: doc/uart_apb_tx.md
# uart_apb_tx

Serial transmitter that sits directly downstream of the UART APB datapath. It consumes that stage's `set`, `din`, `mode` and `baud` outputs and shifts one asynchronous frame onto the `tx` line. Each frame is a start bit, 8 or 10 data bits sent LSB-first, an optional parity bit and one stop bit. It reports `busy` and a one-cycle `done` pulse back to the control/status path.

## Interface
Parameters:
- `BAUD_W`, default 20: width of the baud divisor; matches the `baud` output of the APB datapath.
- `IDLE_LVL`, default 1'b1: line level driven on `tx` when idle and during the stop bit.

Ports:
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: reset, **synchronous, active-high**. One clock; no other clock or reset.
- `set` input 1: transmit request, level from the datapath. Its rising edge starts a frame.
- `din` input 10: frame payload; only bits [7:0] are used when `mode`=0.
- `mode` input 1: 0 = 8 data bits, 1 = 10 data bits.
- `baud` input BAUD_W: clock cycles per bit; 0 is treated as 1.
- `tx` output 1: serial line.
- `busy` output 1: high while a frame is in flight.
- `done` output 1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. PARITY exists only with the macro defined (see Configuration).
- Request detection:
  - `set` is registered as `set_q`; a request is `set & ~set_q`.
  - A request is accepted only in IDLE. Requests while busy are dropped, not queued.
  - A `set` held high never retransmits.
- Acceptance: `din`, `mode` and `baud` are latched into a shift register, a mode flag and a divisor register. Later input changes do not affect the frame in flight.
- Bit timer:
  - Counts 0..max(baud,1)-1 and wraps. A wrap ends the current bit.
  - The timer is cleared on acceptance.
- Transitions on timer wrap:
  - START → DATA.
  - DATA: shifts right and increments the bit counter. After bit 7 (mode 0) or bit 9 (mode 1) it goes to PARITY if enabled, else STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Line levels:
  - START = 0.
  - DATA = shift_reg[0].
  - PARITY = even parity over the transmitted data bits.
  - STOP and IDLE = IDLE_LVL.
- `done` is asserted in the cycle the FSM leaves STOP. A new request in that same cycle is not accepted; it must arrive while IDLE.
- Reset values: `tx`=IDLE_LVL, `busy`=0, `done`=0, state=IDLE, `set_q`=0, all counters 0.
- Reset mid-frame: the frame is aborted. `tx` returns to IDLE_LVL on the clock after `rst` is sampled, and no `done` is generated.
- Divisor width: `baud` up to 2^20-1 is legal. The timer is BAUD_W bits and never overflows.

## Timing
- Request: `set` rises and is sampled at edge N.
  - From N+1, `tx`=0 for B = max(baud,1) cycles, and `busy`=1.
  - Each subsequent bit lasts exactly B cycles.
- Frame length F = (2 + D + P)·B cycles, where D = 8 or 10 data bits and P = 1 with parity, else 0.
- Completion:
  - `done` is high during cycle N+F, the last STOP cycle, for exactly one cycle.
  - `busy` falls at N+F+1.
- Earliest next frame: a `set` rising edge sampled at N+F+1 or later.

## Configuration
- `UART_APB_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - One even-parity bit is inserted after the data bits; the parity bit makes the total count of ones over data+parity even.
  - F includes P=1.
- Not defined:
  - No PARITY state and no parity logic.
  - Data is followed directly by the stop bit; P=0.

## Structure
- Shared package `uart_apb_pkg` holds:
  - the FSM state typedef,
  - the `BAUD_W` default,
  - data-length constants (8/10),
  - the idle line level.
- Sub-module `uart_apb_baud_tick`:
  - contains the bit-timer counter, clear input and wrap-tick output;
  - is reusable later by the receiver.
- The top level holds edge detect, input latches, the FSM, the shift register and the bit counter.

## Test plan
- Basic frame: reset, `baud`=4, `mode`=0, `din`=0x0A5, pulse `set` → `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `done` pulses at cycle 40 after the sampled edge; `busy` falls at 41.
- 10-bit frame: `mode`=1, `din`=0x3FF, `baud`=2 → start bit, ten 1s, stop bit; F=24, plus 2 more with `UART_APB_TX_PARITY_EN` (parity bit 0).
- Held request and retrigger: hold `set` high for 100 cycles with `baud`=1 → exactly one frame and one `done`. Toggling `set` mid-frame is ignored.
- Divisor and latching: `baud`=0 gives 1 cycle per bit. Changing `din` and `baud` mid-frame leaves the in-flight bit values and durations unchanged.
- Reset mid-frame: assert `rst` during DATA → `tx`=1 and `busy`=0 next cycle, no `done`. The next request yields a clean full frame.
- Parity (macro on): `din`=0x007, `mode`=0 → parity bit 1 (three ones). `din`=0x003 → parity bit 0.
